// File: rtl/nbit_seq_shifter.sv
// Iterative SLL/SRL/SRA shifter moving at most STEP bit positions per clock, with a start/done handshake.
// Optional rotate-left for mode 11 is enabled by defining SHIFTER_ROTATE_EN.
module nbit_seq_shifter #(
    parameter int N    = 32,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic [N-1:0]         data_in,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         result
);

    localparam int SW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROL = 2'b11;

    localparam logic [SW-1:0] STEP_K = SW'(STEP);

    logic [1:0]    state_q,  state_d;
    logic [N-1:0]  data_q,   data_d;
    logic [SW-1:0] rem_q,    rem_d;
    logic [1:0]    op_q,     op_d;
    logic          fill_q,   fill_d;
    logic [N-1:0]  result_q, result_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic [SW-1:0] step_k;
    logic [N-1:0]  sll_v;
    logic [N-1:0]  srl_v;
    logic [N-1:0]  sra_v;
    logic [N-1:0]  fill_mask;
    logic [N-1:0]  shift_v;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [SW:0] N_W = (SW+1)'(N);
    logic [SW:0]   rot_back;
    logic [N-1:0]  rol_v;
`endif

    // Amount moved this cycle: the remaining distance, capped at STEP.
    always_comb begin
        if (rem_q < STEP_K) begin
            step_k = rem_q;
        end else begin
            step_k = STEP_K;
        end
    end

    // One step of the working register in the latched direction.
    always_comb begin
        sll_v     = data_q << step_k;
        srl_v     = data_q >> step_k;
        fill_mask = ~({N{1'b1}} >> step_k);
        if (fill_q) begin
            sra_v = srl_v | fill_mask;
        end else begin
            sra_v = srl_v;
        end
`ifdef SHIFTER_ROTATE_EN
        // Bits leaving the MSB come back in at the LSB end.
        rot_back = N_W - {1'b0, step_k};
        rol_v    = sll_v | (data_q >> rot_back);
`endif
        case (op_q)
            M_SLL:   shift_v = sll_v;
            M_SRL:   shift_v = srl_v;
            M_SRA:   shift_v = sra_v;
`ifdef SHIFTER_ROTATE_EN
            M_ROL:   shift_v = rol_v;
`else
            M_ROL:   shift_v = sll_v;
`endif
            default: shift_v = sll_v;
        endcase
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        op_d     = op_q;
        fill_d   = fill_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d = data_in;
                    rem_d  = shamt;
                    op_d   = mode;
                    if (mode == M_SRA) begin
                        fill_d = data_in[N-1];
                    end else begin
                        fill_d = 1'b0;
                    end
                    if (shamt == {SW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                data_d = shift_v;
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                result_d = data_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            data_q   <= {N{1'b0}};
            rem_q    <= {SW{1'b0}};
            op_q     <= 2'b00;
            fill_q   <= 1'b0;
            result_q <= {N{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_nbit_seq_shifter.sv
// Scoreboard bench: two shifter instances (STEP=1 and STEP=4) share stimulus; a bit-serial model predicts results and done timing.
module tb_nbit_seq_shifter;

    localparam int N  = 32;
    localparam int SW = 5;
    localparam int STEPS [2] = '{1, 4};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [SW-1:0] shamt;
    logic [N-1:0]  data_in;
    logic [1:0]    busy_v;
    logic [1:0]    done_v;
    logic [N-1:0]  res_v [2];

    nbit_seq_shifter #(.N(N), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt), .data_in(data_in),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]));

    nbit_seq_shifter #(.N(N), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt), .data_in(data_in),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]));

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    typedef struct {
        logic [N-1:0] res;
        int           done_cyc;
        int           busy_len;
    } exp_t;

    exp_t q [2][$];
    int tests = 0;
    int fails = 0;

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: apply the operation one bit position at a time.
    function automatic logic [N-1:0] ref_shift(input logic [1:0] m, input int s, input logic [N-1:0] d);
        logic [N-1:0] v;
        v = d;
        for (int i = 0; i < s; i++) begin
            case (m)
                2'b01:   v = {1'b0, v[N-1:1]};
                2'b10:   v = {v[N-1], v[N-1:1]};
`ifdef SHIFTER_ROTATE_EN
                2'b11:   v = {v[N-2:0], v[N-1]};
`endif
                default: v = {v[N-2:0], 1'b0};
            endcase
        end
        return v;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Monitor: compare every done pulse against the oldest pending expectation.
    initial begin
        int   bcnt [2];
        exp_t e;
        bcnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_seen === 1'b1) begin
                    bcnt[i] = 0;
                end else begin
                    if (busy_v[i] === 1'b1) bcnt[i]++;
                    if (done_v[i] === 1'b1) begin
                        if (q[i].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL spurious_done_step%0d: actual done=1 required done=0", STEPS[i]);
                        end else begin
                            e = q[i].pop_front();
                            check_vec($sformatf("result_step%0d", STEPS[i]), res_v[i], e.res);
                            check_int($sformatf("done_cycle_step%0d", STEPS[i]), cyc, e.done_cyc);
                            check_int($sformatf("busy_len_step%0d", STEPS[i]), bcnt[i], e.busy_len);
                        end
                        bcnt[i] = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] m, input int s, input logic [N-1:0] d, input bit poke);
        int   waited;
        exp_t e;
        waited = 0;
        while (busy_v != 2'b00 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (busy_v != 2'b00) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: actual busy=%b required 00", busy_v);
        end
        mode    = m;
        shamt   = SW'(s);
        data_in = d;
        start   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e.res      = ref_shift(m, s, d);
            e.done_cyc = cyc + 2 + ceil_div(s, STEPS[i]);
            e.busy_len = 1 + ceil_div(s, STEPS[i]);
            q[i].push_back(e);
        end
        @(negedge clk);
        if (poke) begin
            mode    = 2'($urandom);
            shamt   = SW'($urandom);
            data_in = $urandom;
            @(negedge clk);
        end
        start   = 1'b0;
        mode    = 2'($urandom);
        shamt   = SW'($urandom);
        data_in = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_vec($sformatf("%s_busy_step%0d", tag, STEPS[i]), {31'd0, busy_v[i]}, 32'd0);
            check_vec($sformatf("%s_done_step%0d", tag, STEPS[i]), {31'd0, done_v[i]}, 32'd0);
            check_vec($sformatf("%s_result_step%0d", tag, STEPS[i]), res_v[i], 32'd0);
        end
    endtask

    initial begin
        int waited;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        shamt   = 5'd0;
        data_in = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Abort mid-operation: nothing may ever complete for this request.
        issue(2'b00, 20, 32'h0000_0001, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midop_reset");
        repeat (30) @(negedge clk);

        issue(2'b00, 5,  32'h0000_0001, 1'b0);
        issue(2'b10, 7,  32'h8000_0000, 1'b0);
        issue(2'b01, 31, 32'hF000_000F, 1'b0);
        issue(2'b01, 0,  32'h1234_5678, 1'b0);
        issue(2'b11, 1,  32'h8000_0001, 1'b0);
        issue(2'b10, 9,  32'h7654_3210, 1'b1);
        issue(2'b00, 0,  32'hDEAD_BEEF, 1'b1);
        issue(2'b11, 31, 32'hC000_0003, 1'b0);
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), int'($urandom_range(0, 31)), $urandom, 1'($urandom));
        end

        waited = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check_int("drain_step1", q[0].size(), 0);
        check_int("drain_step4", q[1].size(), 0);
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nbit_seq_shifter.md
Name: nbit_seq_shifter

Overview:
- Parametrised multi-cycle shifter. Successor to the fixed 1-bit left shifter.
- Handles variable shift amount and direction: logical left, logical right, arithmetic right.
- Shifts at most STEP bit positions per clock.
- Iterative shift unit for datapath or multi-cycle ALU paths where a full barrel shifter is too costly. Uses a start/done handshake.

Parameters:
- N, 32: data width in bits. Legal: N >= 2.
- STEP, 1: maximum bit positions shifted per cycle. Legal: 1 <= STEP <= N-1.
- SW (localparam), $clog2(N): shift-amount width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (see Optional Feature).
- shamt  input  SW  shift amount, 0..N-1.
- data_in  input  N  operand.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  N  shifted value.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state updates on rising clk; rst is sampled at the edge.
- Reset state: IDLE, busy=0, done=0, result=0, internal data, count and fill registers = 0.
- rst has priority over all events, including mid-shift; the in-flight operation is discarded with no done pulse.
- States:
  - IDLE, start=1: latch data_in into the working register, shamt into rem, mode into op. For SRA, also latch fill=data_in[N-1]. Go to DONE if shamt==0, else to SHIFT.
  - IDLE, start=0: stay in IDLE; result holds its last value.
  - SHIFT: each cycle shift the working register by k=min(rem,STEP) in direction op. Set rem=rem-k.
    - Fill bits: zeros for SLL/SRL; latched fill bit for SRA.
    - Go to DONE when the new rem==0, else stay in SHIFT.
  - DONE: done=1 and result=working register, both for exactly one cycle, then go to IDLE.
- Latency: with the accept edge as edge 0, done is high in the cycle following edge 1+ceil(shamt/STEP).
  - shamt=0 gives a 1-edge latency; result equals data_in.
- start while busy (SHIFT or DONE) is ignored; no queuing. start in the cycle after DONE (IDLE again) is accepted normally.
- result updates only on the DONE transition and is stable from then until the next DONE.
- Inputs mode, shamt and data_in are don't-care except on the accepting cycle.
- No overflow flag. Bits shifted out are discarded.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: mode 11 = rotate left. Bits leaving the MSB re-enter at the LSB, k per SHIFT cycle; same latency as the other modes.
- Undefined: mode 11 executes exactly as SLL (00) and no rotate logic is built.

Test Plan:
- Reset mid-operation: N=32, STEP=1, SLL shamt=20 on 0x0000_0001, assert rst after 5 shift cycles -> next cycle busy=0, done=0, result=0. No done pulse ever follows.
- Basic SLL: N=32, STEP=1, SLL data_in=0x0000_0001, shamt=5 -> done high in cycle after edge 6; result=0x0000_0020; busy high for exactly 6 cycles.
- SRA with sign fill, partial last step: STEP=4, SRA data_in=0x8000_0000, shamt=7 -> SHIFT takes 2 cycles (4 then 3); result=0xFF00_0000; done after edge 3.
- SRL and zero shift: STEP=4, SRL 0xF000_000F shamt=31 -> result=0x0000_0001 after edge 9. Then shamt=0 on 0x1234_5678 -> result=0x1234_5678 and done after edge 1.
- Ignored start, back-to-back: start re-asserted with new operands during SHIFT -> first result unaffected and no extra done. start asserted in the cycle after done -> accepted, second op completes correctly.
- Mode 11: data_in=0x8000_0001, shamt=1, STEP=1:
  - With SHIFTER_ROTATE_EN: result=0x0000_0003.
  - Without: result=0x0000_0002.
